// File: rtl/sram_video_fetcher.sv
// -----------------------------------------------------------------------------
// sram_video_fetcher
//
// Pixel source for the PAL progressive sync generator. Reads a 256x192,
// 8-bit-per-pixel (GGGRRRBB) framebuffer from an external asynchronous SRAM,
// two pixel clocks ahead of the beam, and arbitrates a single host write port
// into the same SRAM during cycles that video fetch does not need.
//
// Build option:
//   BORDER_EN  defined   -> border colour is shown outside the picture window
//              undefined -> black outside the window, border port ignored
//
// Ports:
//   clk        pixel clock (shared with the sync generator)
//   rst        synchronous reset, active-high
//   hcnt/vcnt  registered beam counters from the sync generator
//   border     border colour {G,R,B}
//   wr_req     host write request, held until wr_ack
//   wr_addr    host write address
//   wr_data    host write data
//   wr_ack     one-cycle pulse, coincident with the SRAM write strobe
//   sram_addr  SRAM address (registered)
//   sram_dq_o  SRAM write data (registered)
//   sram_dq_i  SRAM read data
//   sram_we_n  SRAM write enable, active-low (registered)
//   sram_oe_n  SRAM output enable, active-low (registered)
//   ro/go/bo   3-bit pixel colour to the sync generator (registered)
// -----------------------------------------------------------------------------
module sram_video_fetcher #(
  parameter logic [8:0] H_START     = 9'd96,
  parameter logic [8:0] V_START     = 9'd60,
  parameter logic [8:0] END_COUNT_H = 9'd447
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  hcnt,
  input  logic [8:0]  vcnt,
  input  logic [2:0]  border,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_dq_o,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [2:0]  ro,
  output logic [2:0]  go,
  output logic [2:0]  bo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dq_q, dq_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        ack_q, ack_d;
  logic        win_q;
  logic [2:0]  ro_q, go_q, bo_q;

  // ---------------------------------------------------------------------------
  // Lookahead columns. f_now is the column whose address is issued this cycle
  // (displayed two clocks later); f_next is the one issued next cycle. Both
  // wrap at the end of the line but keep the current vcnt.
  // ---------------------------------------------------------------------------
  logic [8:0] f_now_sum, f_next_sum;
  logic [8:0] f_now, f_next;
  logic       v_in, h_in_now, h_in_next;
  logic       fetch_now, fetch_next;
  logic [7:0] row, col;
  logic [15:0] fetch_addr;

  assign f_now_sum  = hcnt + 9'd2;
  assign f_next_sum = hcnt + 9'd3;
  assign f_now  = (f_now_sum  > END_COUNT_H) ? f_now_sum  - (END_COUNT_H + 9'd1) : f_now_sum;
  assign f_next = (f_next_sum > END_COUNT_H) ? f_next_sum - (END_COUNT_H + 9'd1) : f_next_sum;

  assign v_in      = (vcnt >= V_START) && (vcnt <= V_START + 9'd191);
  assign h_in_now  = (f_now  >= H_START) && (f_now  <= H_START + 9'd255);
  assign h_in_next = (f_next >= H_START) && (f_next <= H_START + 9'd255);

  assign fetch_now  = v_in && h_in_now;
  // Used to keep a write from starting when its WRITE cycle would be a fetch.
  assign fetch_next = v_in && h_in_next;

  assign row        = 8'(vcnt - V_START);
  assign col        = 8'(f_now - H_START);
  assign fetch_addr = {row, col};

  // ---------------------------------------------------------------------------
  // Pixel decode (GGGRRRBB) and out-of-window colour.
  // ---------------------------------------------------------------------------
  logic [2:0] pix_r, pix_g, pix_b;
  logic [2:0] bord_r, bord_g, bord_b;

  assign pix_g = sram_dq_i[7:5];
  assign pix_r = sram_dq_i[4:2];
  assign pix_b = {sram_dq_i[1], sram_dq_i[0], sram_dq_i[1]};

`ifdef BORDER_EN
  assign bord_g = {3{border[2]}};
  assign bord_r = {3{border[1]}};
  assign bord_b = {3{border[0]}};
`else
  logic unused_border;
  assign unused_border = ^border;
  assign bord_g = 3'b000;
  assign bord_r = 3'b000;
  assign bord_b = 3'b000;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration FSM: next-state and SRAM control. Fetch always overrides.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    we_n_d  = 1'b1;
    oe_n_d  = oe_n_q;
    ack_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_req && !fetch_now && !fetch_next) begin
          state_d = WRITE;
          addr_d  = wr_addr;
          dq_d    = wr_data;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b0;
          // Ack is registered alongside the strobe so it marks the WRITE cycle.
          ack_d   = 1'b1;
        end
      end
      WRITE: begin
        state_d = RECOVER;
        oe_n_d  = 1'b0;
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fetch_now) begin
      addr_d = fetch_addr;
      oe_n_d = 1'b0;
      we_n_d = 1'b1;
      ack_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 16'd0;
      dq_q    <= 8'd0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b0;
      ack_q   <= 1'b0;
      win_q   <= 1'b0;
      ro_q    <= 3'd0;
      go_q    <= 3'd0;
      bo_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      ack_q   <= ack_d;
      // win_q marks that sram_dq_i this cycle belongs to a fetched pixel.
      win_q   <= fetch_now;
      if (win_q) begin
        ro_q <= pix_r;
        go_q <= pix_g;
        bo_q <= pix_b;
      end else begin
        ro_q <= bord_r;
        go_q <= bord_g;
        bo_q <= bord_b;
      end
    end
  end

  assign sram_addr = addr_q;
  assign sram_dq_o = dq_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign wr_ack    = ack_q;
  assign ro        = ro_q;
  assign go        = go_q;
  assign bo        = bo_q;

endmodule

// File: tb/tb_sram_video_fetcher.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_video_fetcher
//
// Drives hcnt/vcnt directly, models the asynchronous SRAM, and checks the
// pixel stream against a scoreboard built from a reference copy of memory.
// Decode vectors come from a table; write arbitration and reset corners are
// covered by short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_sram_video_fetcher;

  localparam int H_START = 96;
  localparam int V_START = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  hcnt, vcnt;
  logic [2:0]  border;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic [7:0]  sram_dq_i;
  logic        sram_we_n, sram_oe_n;
  logic [2:0]  ro, go, bo;

  sram_video_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .border    (border),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_i (sram_dq_i),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .ro        (ro),
    .go        (go),
    .bo        (bo)
  );

  always #5 clk = ~clk;

  // Background contents of never-written locations.
  function automatic logic [7:0] pat8(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // ---------------- SRAM model (owned by one process) ----------------
  bit [7:0]    sram_mem [0:65535];
  bit          sram_wr  [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'd0;
  logic [7:0]  pl_data = 8'd0;

  assign sram_dq_i = sram_wr[sram_addr] ? sram_mem[sram_addr] : pat8(sram_addr);

  always @(posedge clk) begin
    if (pl_en) begin
      sram_mem[pl_addr] <= pl_data;
      sram_wr[pl_addr]  <= 1'b1;
    end else if (sram_we_n === 1'b0) begin
      sram_mem[sram_addr] <= sram_dq_o;
      sram_wr[sram_addr]  <= 1'b1;
    end
  end

  // ---------------- reference memory (bench expectation) ----------------
  bit [7:0] ref_mem [0:65535];
  bit       ref_w   [0:65535];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_w[a] ? ref_mem[a] : pat8(a);
  endfunction

  task automatic ref_set(input logic [15:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    ref_w[a]   = 1'b1;
  endtask

  // {r,g,b}
  function automatic logic [8:0] dec(input logic [7:0] p);
    return {p[4:2], p[7:5], p[1], p[0], p[1]};
  endfunction

  function automatic logic [8:0] bord_rgb(input logic [2:0] b);
`ifdef BORDER_EN
    return {{3{b[1]}}, {3{b[2]}}, {3{b[0]}}};
`else
    return 9'd0;
`endif
  endfunction

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (hcnt=%0d vcnt=%0d)", name, act, exp, hcnt, vcnt);
    end
  endtask

  typedef struct {
    bit         win;
    logic [8:0] rgb;
  } sb_t;
  sb_t        sbq[$];
  logic [2:0] border_nxt = 3'b000;
  logic [2:0] border_prev;

  // Apply one cycle of beam inputs; compare the pixel due now and queue the
  // one that these inputs will produce two cycles later.
  task automatic drive(input logic [8:0] h, input logic [8:0] v);
    int  f;
    bit  win;
    sb_t e, p;
    logic [8:0] exp;
    border_prev = border;
    border = border_nxt;
    hcnt = h;
    vcnt = v;
    if (rst) begin
      sbq.delete();
    end else begin
      f   = (int'(h) + 2) % 448;
      win = (f >= H_START) && (f <= H_START + 255) &&
            (int'(v) >= V_START) && (int'(v) <= V_START + 191);
      e.win = win;
      e.rgb = win ? dec(ref_rd(16'((int'(v) - V_START) * 256 + (f - H_START)))) : 9'd0;
      if (sbq.size() >= 2) begin
        p   = sbq.pop_front();
        exp = p.win ? p.rgb : bord_rgb(border_prev);
        chk("pixel", {23'd0, ro, go, bo}, {23'd0, exp});
      end
      sbq.push_back(e);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- decode vector table (row 0) ----------------
  typedef struct {
    int         col;
    logic [7:0] pix;
    logic [2:0] er, eg, eb;
  } dvec_t;
  dvec_t dv [8];

  // Scan one full line; optionally raise a write at req_h and check when the
  // strobe appears, that it lasts one cycle, and that memory took the data.
  task automatic scan_line(input int v, input int req_h, input logic [15:0] a,
                           input logic [7:0] d, input int exp_low);
    int first_low = -1;
    int n_low = 0;
    for (int h = 0; h < 448; h++) begin
      if (h == req_h) begin
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        ref_set(a, d);
      end
      drive(9'(h), 9'(v));
      chk("ack_vs_we", {31'd0, wr_ack}, {31'd0, ~sram_we_n});
      if (sram_we_n === 1'b0) begin
        n_low++;
        if (first_low < 0) begin
          first_low = h;
          chk("wr_addr", {16'd0, sram_addr}, {16'd0, a});
          chk("wr_data", {24'd0, sram_dq_o}, {24'd0, d});
          chk("wr_oe_n", {31'd0, sram_oe_n}, 32'd1);
        end
      end
      if (wr_ack === 1'b1) wr_req = 1'b0;
      if (v == V_START) begin
        if (h == H_START - 1) chk("first_addr", {16'd0, sram_addr}, 32'd0);
        for (int k = 0; k < 8; k++)
          if (h == H_START + dv[k].col)
            chk("tbl_pixel", {23'd0, ro, go, bo}, {23'd0, dv[k].er, dv[k].eg, dv[k].eb});
        if (h == H_START + 256) chk("after_last", {23'd0, ro, go, bo}, {23'd0, bord_rgb(3'b101)});
      end
      advance();
    end
    if (req_h >= 0) begin
      chk("first_we_low_hcnt", 32'(first_low), 32'(exp_low));
      chk("we_low_cycles", 32'(n_low), 32'd1);
      chk("sram_content", {24'd0, sram_mem[a]}, {24'd0, d});
    end
    wr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dv[0] = '{0,   8'hE3, 3'b000, 3'b111, 3'b111};
    dv[1] = '{1,   8'h02, 3'b000, 3'b000, 3'b101};
    dv[2] = '{2,   8'h01, 3'b000, 3'b000, 3'b010};
    dv[3] = '{3,   8'h00, 3'b000, 3'b000, 3'b000};
    dv[4] = '{100, 8'hA5, 3'b001, 3'b101, 3'b010};
    dv[5] = '{128, 8'h4A, 3'b010, 3'b010, 3'b101};
    dv[6] = '{254, 8'hFF, 3'b111, 3'b111, 3'b111};
    dv[7] = '{255, 8'h1C, 3'b111, 3'b000, 3'b000};

    rst = 1'b1;
    hcnt = 9'd0;
    vcnt = 9'd0;
    border = 3'b000;
    border_prev = 3'b000;
    wr_req = 1'b1;
    wr_addr = 16'h1234;
    wr_data = 8'hAA;

    // Reset held 3 cycles with a pending write request.
    for (int i = 0; i < 3; i++) begin
      advance();
      drive(9'(i), 9'd0);
      chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rst_ack", {31'd0, wr_ack}, 32'd0);
      chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd0);
      chk("rst_addr", {16'd0, sram_addr}, 32'd0);
      chk("rst_rgb", {23'd0, ro, go, bo}, 32'd0);
    end
    rst = 1'b0;
    wr_req = 1'b0;

    // Preload the decode table into row 0 (vertical blanking, no fetch).
    border_nxt = 3'b101;
    for (int i = 0; i < 8; i++) begin
      pl_en   = 1'b1;
      pl_addr = 16'(dv[i].col);
      pl_data = dv[i].pix;
      ref_set(16'(dv[i].col), dv[i].pix);
      drive(9'(i + 3), 9'd0);
      advance();
    end
    pl_en = 1'b0;

    // Row 0: first/last pixel timing and decode table.
    scan_line(V_START, -1, 16'd0, 8'd0, 0);

    // Host writes in horizontal blanking: back-to-back, one per 3 cycles.
    for (int h = 0; h < 10; h++) begin
      drive(9'(h), 9'(V_START + 1));
      advance();
    end
    wr_req = 1'b1; wr_addr = 16'h0100; wr_data = 8'h5A; ref_set(16'h0100, 8'h5A);
    drive(9'd10, 9'(V_START + 1));
    chk("blank_pre_we_n", {31'd0, sram_we_n}, 32'd1);
    advance();
    drive(9'd11, 9'(V_START + 1));
    chk("blank_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("blank_addr", {16'd0, sram_addr}, 32'h0100);
    chk("blank_dq", {24'd0, sram_dq_o}, 32'h5A);
    chk("blank_ack", {31'd0, wr_ack}, 32'd1);
    chk("blank_oe_n", {31'd0, sram_oe_n}, 32'd1);
    wr_addr = 16'h0101; wr_data = 8'h3C; ref_set(16'h0101, 8'h3C);
    advance();
    drive(9'd12, 9'(V_START + 1));
    chk("recover_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("recover_ack", {31'd0, wr_ack}, 32'd0);
    chk("recover_oe_n", {31'd0, sram_oe_n}, 32'd0);
    advance();
    drive(9'd13, 9'(V_START + 1));
    chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    advance();
    drive(9'd14, 9'(V_START + 1));
    chk("b2b_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("b2b_addr", {16'd0, sram_addr}, 32'h0101);
    chk("b2b_dq", {24'd0, sram_dq_o}, 32'h3C);
    chk("b2b_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    advance();
    drive(9'd15, 9'(V_START + 1));
    chk("b2b_done_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("b2b_done_ack", {31'd0, wr_ack}, 32'd0);
    advance();

    // Requests during the window wait for the first free cycle after it.
    scan_line(V_START + 1, H_START + 10, 16'h2000, 8'h77, H_START + 255);
    scan_line(V_START + 2, H_START - 3,  16'h2100, 8'h66, H_START + 255);
    // Vertical blanking: immediate grant, out-of-range address still written.
    scan_line(10, H_START + 50, 16'hC005, 8'h99, H_START + 51);
    // Last visible row and first row below the picture.
    scan_line(V_START + 191, -1, 16'd0, 8'd0, 0);
    scan_line(V_START + 192, -1, 16'd0, 8'd0, 0);

    // Reset during a WRITE cycle.
    wr_req = 1'b1; wr_addr = 16'hF000; wr_data = 8'h11; ref_set(16'hF000, 8'h11);
    drive(9'd20, 9'd0);
    advance();
    drive(9'd21, 9'd0);
    chk("midrst_write_cycle", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    wr_req = 1'b0;
    advance();
    drive(9'd22, 9'd0);
    chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("midrst_ack", {31'd0, wr_ack}, 32'd0);
    chk("midrst_rgb", {23'd0, ro, go, bo}, 32'd0);
    rst = 1'b0;
    advance();
    for (int h = 23; h < 30; h++) begin
      drive(9'(h), 9'd0);
      chk("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("post_rst_ack", {31'd0, wr_ack}, 32'd0);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_video_fetcher.md
Name: sram_video_fetcher

Overview:
- Upstream pixel source for the PAL progressive sync generator. Takes its registered hcnt/vcnt and reads a 256x192, 8-bit-per-pixel framebuffer from external SRAM. Drives 3-bit ri/gi/bi with a fixed two-cycle lookahead, so pixels land on the correct beam position.
- Arbitrates one host write port into the same SRAM. Writes are granted only in cycles not needed for video fetch.

Parameters:
- H_START, 9'd96, hcnt value at which framebuffer pixel column 0 is displayed
- V_START, 9'd60, vcnt value of framebuffer row 0
- END_COUNT_H, 9'd447, last hcnt value of a line (wrap 447->0)

Ports:
- clk  in  1  pixel clock, same clock as the sync generator
- rst  in  1  synchronous reset, active-high
- hcnt  in  9  horizontal counter from sync generator
- vcnt  in  9  vertical counter from sync generator
- border  in  3  border colour {G,R,B}
- wr_req  in  1  host write request, held until wr_ack
- wr_addr  in  16  host write address (0..49151)
- wr_data  in  8  host write data
- wr_ack  out  1  one-cycle pulse: write performed
- sram_addr  out  16  SRAM address (registered)
- sram_dq_o  out  8  SRAM write data (registered)
- sram_dq_i  in  8  SRAM read data
- sram_we_n  out  1  SRAM write enable, active-low (registered)
- sram_oe_n  out  1  SRAM output enable, active-low (registered)
- ro/go/bo  out  3 each  pixel colour to sync generator ri/gi/bi (registered)

Behaviour:
- Reset values: sram_we_n=1, sram_oe_n=0, sram_addr=0, sram_dq_o=0, wr_ack=0, ro/go/bo=0, state=IDLE.
- Fetch lookahead f = (hcnt+2) mod 448. The window is active when f ∈ [H_START, H_START+255] and vcnt ∈ [V_START, V_START+191]. Wrap is computed with 9-bit arithmetic and compared against END_COUNT_H. Lookahead does not carry into the next line.
- FETCH cycle (fetch_now true):
  - sram_addr <= (vcnt-V_START)*256 + (f-H_START), i.e. {row[7:0], col[7:0]}.
  - sram_oe_n <= 0, sram_we_n <= 1.
  - Next cycle: SRAM data is captured into the pixel register.
  - Total latency: address issue at hcnt = H_START+k-2 gives ro/go/bo for pixel k while hcnt = H_START+k.
- Pixel decode of byte P[7:0] = GGGRRRBB: go=P[7:5], ro=P[4:2], bo={P[1],P[0],P[1]}.
- Outside the window (a one-cycle-delayed window flag aligned with the data), ro/go/bo = {R,R,R},{G,G,G},{B,B,B} from border.
- State machine (evaluated each cycle; fetch_now has absolute priority):
  - IDLE: if fetch_now -> stay (fetch issued). Else if wr_req -> WRITE: sram_addr<=wr_addr, sram_dq_o<=wr_data, sram_oe_n<=1, sram_we_n<=0.
  - WRITE: sram_we_n<=1; wr_ack pulses 1 this cycle; -> RECOVER.
  - RECOVER: one dead cycle, no write issued, fetch allowed. Host must drop or update wr_req by this cycle; -> IDLE.
  - A write is never started when fetch_now would be true in the following cycle. This guarantees a WRITE cycle never overlaps a fetch.
- Write throughput: at most one write per 3 cycles, border/blanking only. A pending request during the window waits; no loss, no ack.
- wr_addr ≥ 49152: written anyway (address truncation is the host's responsibility).
- Reset mid-write: sram_we_n high on the next edge, no wr_ack, state IDLE.
- vcnt/hcnt frame wrap (311->0, 447->0): no special case beyond the window compare.

Optional Feature:
- BORDER_EN.
- Defined: border colour is output outside the window as above.
- Undefined: outside the window ro/go/bo=000 and the border port is unused. Arbitration and fetch are identical in both builds.

Test Plan:
- Reset asserted 3 cycles with wr_req=1 -> sram_we_n=1, wr_ack=0, ro/go/bo=0 throughout.
- Preload SRAM[0]=8'hE3, run hcnt to H_START-2 at vcnt=V_START -> sram_addr=0 at hcnt=H_START-1; ro=000, go=111, bo=111 at hcnt=H_START.
- Last pixel: SRAM[255]=8'h1C -> at hcnt=H_START+255, ro=111, go=000, bo=000; at H_START+256 the border colour is shown.
- wr_req with addr 16'h0100, data 8'h5A at hcnt=10 (blanking) -> sram_we_n=0 for exactly 1 cycle with sram_addr=16'h0100, sram_dq_o=8'h5A; wr_ack 1 cycle; then 1 RECOVER cycle.
- wr_req raised at hcnt=H_START+10 inside the window -> no we_n low until hcnt ≥ H_START+254; the write occurs at the first non-fetch cycle, and no fetch address is lost or corrupted.
- border=3'b101 outside the window -> BORDER_EN gives ro=000, go=111, bo=111; without BORDER_EN, 000/000/000.
